pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central pipeline sequencing controller for the openmips core. It merges stall requests from ID (load-use) and EX (external and multi-cycle ops such as div/madd). It owns the multi-cycle operation counter and issues flush plus redirect PC on exceptions. The per-stage stall vector it drives feeds pc_reg and the if_id, id_ex, ex_mem and mem_wb pipeline registers.

Parameters:
EBASE, 32'h00000000, exception vector base address
PERF_W, 32, width of the saturating stall-cycle counter

Ports:
clk  input  1  core clock
rst  input  1  reset, synchronous, active-high
stallreq_id  input  1  load-use stall request from ID
stallreq_ex  input  1  generic EX stall request
mc_start  input  1  EX begins a multi-cycle op this cycle
mc_cycles  input  6  stall length N of the op, sampled with mc_start
excepttype_i  input  32  exception type from MEM, 0 = none
cp0_epc_i  input  32  current EPC from CP0
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
flush  output  1  flush all pipeline registers
new_pc  output  32  redirect target, valid when flush=1
mc_busy  output  1  multi-cycle op in progress
mc_done  output  1  one-cycle pulse: EX result ready, pipeline released
stall_cnt  output  PERF_W  count of cycles with stall!=0, saturating

Behaviour:
- Reset: while rst=1 at a clock edge, the FSM goes to IDLE and the counter, mc_done and stall_cnt clear. While rst=1 all outputs are forced to 0, including the combinational outputs.
- FSM states: IDLE, MULTI, RECOVER.
- Output priority, combinational from state and inputs: exception > MULTI/mc_start > stallreq_ex > stallreq_id.
- Exception (excepttype_i!=0, any state):
  - Same cycle: flush=1, stall=6'b000000.
  - new_pc: 32'h1 gives EBASE+32'h20. 32'h8, 32'ha, 32'hc, 32'hd give EBASE+32'h40. 32'he (eret) gives cp0_epc_i. Any other non-zero value gives EBASE+32'h40.
  - Next state is RECOVER. An active multi-cycle op is aborted: counter cleared, mc_busy=0, no mc_done.
- When flush=0, new_pc=0.
- IDLE, no exception:
  - mc_start=1 and mc_cycles=N>=1: stall=6'b001111 this cycle (cycle t), counter loads N-1, next state MULTI (or stay IDLE if N=1 with mc_done scheduled).
  - mc_start=1 with N=0: no stall, no mc_done.
  - Otherwise stallreq_ex gives 6'b001111, stallreq_id gives 6'b000111, neither gives 0.
- MULTI:
  - stall=6'b001111 and mc_busy=1. mc_busy is also 1 in cycle t.
  - The counter decrements each cycle; at 0 the next state is IDLE.
  - The stall therefore spans exactly cycles t..t+N-1.
  - mc_done is a registered pulse in cycle t+N, the first unstalled cycle. In that cycle stall follows the IDLE rules.
  - mc_start during MULTI is ignored.
- RECOVER: lasts exactly 1 cycle.
  - flush=0. stallreq_id is masked, because ID holds a bubble.
  - stallreq_ex and mc_start behave as in IDLE; the next state follows the IDLE rules.
  - A new exception has priority.
- stall_cnt increments on every edge where stall!=0 and rst=0, and saturates at all-ones.
- No combinational path from stall or flush to any input.

Decomposition:
- Shared package/include (alongside the existing defines): stall vector constants STALL_NONE, STALL_ID, STALL_EX; exception type codes EXC_INT, EXC_SYSCALL, EXC_INST_INVALID, EXC_TRAP, EXC_OV, EXC_ERET; vector offsets 32'h20 and 32'h40; FSM state encodings.
- One natural sub-module, mc_counter: load, decrement, zero detect, abort, done-pulse register. The rest stays in pipe_stall_ctrl.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with all requests active -> stall=0, flush=0, new_pc=0, stall_cnt=0. After release with no requests -> stall stays 0.
2. Priority: stallreq_id=1 alone -> stall=6'b000111. Then stallreq_id=1 and stallreq_ex=1 -> 6'b001111. Each stalled cycle increments stall_cnt by 1.
3. Multi-cycle: mc_start=1, mc_cycles=5 at cycle t -> stall=6'b001111 and mc_busy=1 for t..t+4. mc_done=1 only at t+5 with stall=0. A second mc_start at t+2 is ignored. mc_cycles=0 -> no stall, no mc_done.
4. Exception vectors, EBASE=32'h00000000:
   - excepttype_i=32'h1 -> flush=1, new_pc=32'h20, stall=0.
   - 32'h8 -> new_pc=32'h40.
   - 32'he with cp0_epc_i=32'h00001100 -> new_pc=32'h00001100.
5. Abort: mc_start with N=8, then excepttype_i=32'hc at t+3 -> flush=1 at t+3, mc_busy=0 from t+4, no mc_done ever. In the RECOVER cycle stallreq_id=1 gives stall=0 and stallreq_ex=1 gives stall=6'b001111.
6. Reset mid-op: rst=1 at t+2 of an N=6 op -> next cycle all outputs 0 and state IDLE. After release, no mc_done pulse.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   - per-stage stall vectors (bit0 PC .. bit5 WB)
//   - exception type codes delivered by MEM
//   - exception vector offsets from EBASE
//   - controller FSM state encoding
//   - exc_target(): maps an exception type to its redirect PC
package pipe_stall_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;  // hold PC, IF, ID
    localparam logic [5:0] STALL_EX   = 6'b001111;  // hold PC, IF, ID, EX

    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam logic [31:0] VEC_OFF_INT = 32'h0000_0020;
    localparam logic [31:0] VEC_OFF_GEN = 32'h0000_0040;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MULTI   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Interrupts use their own vector, eret returns to EPC, every other
    // non-zero type (listed or not) lands on the general vector.
    function automatic logic [31:0] exc_target(input logic [31:0] ebase,
                                               input logic [31:0] excepttype,
                                               input logic [31:0] epc);
        logic [31:0] tgt;
        case (excepttype)
            EXC_INT:          tgt = ebase + VEC_OFF_INT;
            EXC_ERET:         tgt = epc;
            EXC_SYSCALL,
            EXC_INST_INVALID,
            EXC_OV,
            EXC_TRAP:         tgt = ebase + VEC_OFF_GEN;
            default:          tgt = ebase + VEC_OFF_GEN;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_mc_counter.sv
// Multi-cycle operation counter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : start of an op; load_n is its total stall length N (N>=1)
//   dec       : one more stalled cycle of the op has elapsed
//   abort     : exception kills the op; count and pending done are dropped
//   last      : the current cycle is the final stalled cycle of the op
//   done      : registered one-cycle pulse in the first unstalled cycle
module mc_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_n,
    input  logic       dec,
    input  logic       abort,
    output logic       last,
    output logic       done
);

    // Holds the number of stalled cycles still to come, including the
    // current one when in MULTI. The start cycle itself is not counted,
    // hence the N-1 load.
    logic [5:0] cnt;

    assign last = (cnt <= 6'd1);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cnt  <= 6'd0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt  <= load_n - 6'd1;
                done <= (load_n == 6'd1);
            end else if (dec) begin
                cnt  <= cnt - 6'd1;
                done <= last;
            end
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencing controller.
//   Merges load-use (ID) and EX stall requests, sequences multi-cycle EX
//   ops, and on exceptions flushes the pipe and supplies the redirect PC.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (forces outputs 0)
//   stallreq_id    : load-use stall request from ID
//   stallreq_ex    : generic EX stall request
//   mc_start       : EX begins a multi-cycle op; mc_cycles = stall length N
//   excepttype_i   : exception type from MEM, 0 = none
//   cp0_epc_i      : EPC for eret
//   stall          : per-stage hold vector (bit0 PC .. bit5 WB)
//   flush, new_pc  : flush all stages and redirect; new_pc is 0 when flush=0
//   mc_busy        : multi-cycle op occupies EX this cycle
//   mc_done        : one-cycle pulse in the first cycle after the op's stall
//   stall_cnt      : saturating count of cycles with stall != 0
//
// mc_start/mc_done contract: mc_start is a single-cycle request honoured
// only when no op is in flight and no exception is present; an accepted
// op of N>=1 cycles stalls exactly N cycles and is answered by exactly one
// mc_done pulse, unless an exception or reset aborts it (then no mc_done).
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] EBASE  = 32'h0000_0000,
    parameter int          PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              mc_start,
    input  logic [5:0]        mc_cycles,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [PERF_W-1:0] stall_cnt
);

    state_t state, state_nx;

    logic cnt_load, cnt_dec, cnt_abort;
    logic cnt_last, done_q;
    logic [PERF_W-1:0] stall_cnt_q;

    mc_counter u_mc_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .load_n (mc_cycles),
        .dec    (cnt_dec),
        .abort  (cnt_abort),
        .last   (cnt_last),
        .done   (done_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        stall     = STALL_NONE;
        flush     = 1'b0;
        new_pc    = 32'h0;
        mc_busy   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_abort = 1'b0;

        if (rst) begin
            state_nx = ST_IDLE;
        end else if (excepttype_i != 32'h0) begin
            flush     = 1'b1;
            new_pc    = exc_target(EBASE, excepttype_i, cp0_epc_i);
            cnt_abort = 1'b1;
            state_nx  = ST_RECOVER;
        end else if (state == ST_MULTI) begin
            // mc_start is ignored while an op is in flight.
            stall   = STALL_EX;
            mc_busy = 1'b1;
            cnt_dec = 1'b1;
            if (cnt_last) begin
                state_nx = ST_IDLE;
            end
        end else begin
            // IDLE and RECOVER share rules, except that in RECOVER the ID
            // stage holds a flushed bubble so its load-use request is moot.
            state_nx = ST_IDLE;
            if (mc_start && (mc_cycles != 6'd0)) begin
                stall    = STALL_EX;
                mc_busy  = 1'b1;
                cnt_load = 1'b1;
                if (mc_cycles != 6'd1) begin
                    state_nx = ST_MULTI;
                end
            end else if (stallreq_ex) begin
                stall = STALL_EX;
            end else if (stallreq_id && (state != ST_RECOVER)) begin
                stall = STALL_ID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((stall != STALL_NONE) && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign mc_done   = done_q & ~rst;
    assign stall_cnt = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int          PW   = 4;  // small so saturation is reached
    localparam logic [31:0] EB   = 32'h0000_0000;
    localparam int          W    = 6 + 1 + 32 + 1 + 1 + PW;
    localparam int          MAXC = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stallreq_id = 1'b0;
    logic          stallreq_ex = 1'b0;
    logic          mc_start = 1'b0;
    logic [5:0]    mc_cycles = 6'd0;
    logic [31:0]   excepttype_i = 32'h0;
    logic [31:0]   cp0_epc_i = 32'h0;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic          mc_busy;
    logic          mc_done;
    logic [PW-1:0] stall_cnt;

    pipe_stall_ctrl #(.EBASE(EB), .PERF_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cnt    (stall_cnt)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           total = 0;
    int           bad = 0;

    // reference model: remaining stall cycles of the current op, a pending
    // done pulse, whether the last cycle took an exception, cycle counter
    int m_rem = 0;
    bit m_done = 1'b0;
    bit m_recover = 1'b0;
    int m_cnt = 0;

    function automatic string fmt(input logic [W-1:0] v);
        return $sformatf("stall=%b flush=%b pc=%h busy=%b done=%b cnt=%0d",
                         v[W-1 -: 6], v[W-7], v[W-8 -: 32], v[PW+1], v[PW], v[PW-1:0]);
    endfunction

    // driver: apply one cycle of inputs and push the expected outputs
    task automatic step(input logic r, input logic id, input logic ex,
                        input logic ms, input logic [5:0] n,
                        input logic [31:0] exc, input logic [31:0] epc,
                        input string tag);
        logic [5:0]    e_stall;
        logic          e_flush, e_busy, e_done;
        logic [31:0]   e_pc;
        logic [PW-1:0] e_cnt;
        bit            rec;
        @(posedge clk);
        #1;
        rst = r; stallreq_id = id; stallreq_ex = ex; mc_start = ms;
        mc_cycles = n; excepttype_i = exc; cp0_epc_i = epc;
        e_stall = 6'b0; e_flush = 1'b0; e_pc = 32'h0;
        e_busy = 1'b0; e_done = 1'b0; e_cnt = '0;
        if (r) begin
            m_rem = 0; m_done = 1'b0; m_recover = 1'b0; m_cnt = 0;
        end else begin
            e_done = m_done;
            e_cnt  = m_cnt[PW-1:0];
            if (exc != 32'h0) begin
                e_flush = 1'b1;
                if (exc == 32'h1)      e_pc = EB + 32'h20;
                else if (exc == 32'he) e_pc = epc;
                else                   e_pc = EB + 32'h40;
                m_rem = 0; m_done = 1'b0; m_recover = 1'b1;
            end else if (m_rem > 0) begin
                e_stall = 6'b001111; e_busy = 1'b1;
                m_rem = m_rem - 1;
                m_done = (m_rem == 0);
                m_recover = 1'b0;
            end else begin
                rec = m_recover;
                m_recover = 1'b0;
                m_done = 1'b0;
                if (ms && n != 6'd0) begin
                    e_stall = 6'b001111; e_busy = 1'b1;
                    m_rem = int'(n) - 1;
                    m_done = (n == 6'd1);
                end else if (ex) begin
                    e_stall = 6'b001111;
                end else if (id && !rec) begin
                    e_stall = 6'b000111;
                end
            end
            if (e_stall != 6'b0 && m_cnt < MAXC) m_cnt = m_cnt + 1;
        end
        exp_q.push_back({e_stall, e_flush, e_pc, e_busy, e_done, e_cnt});
        tag_q.push_back(tag);
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 6'd0, 32'h0, 32'h0, tag);
    endtask

    // monitor: compare the settled outputs mid-cycle
    always @(negedge clk) begin
        logic [W-1:0] got, exp_v;
        string        t;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            t     = tag_q.pop_front();
            got   = {stall, flush, new_pc, mc_busy, mc_done, stall_cnt};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL %s: got %s expected %s", t, fmt(got), fmt(exp_v));
            end
        end
    end

    logic [31:0] codes [8] = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3, 32'h8000_0000};

    initial begin
        // 1. reset with every request active
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 6'd5, 32'h1, 32'h1234, "reset_hold");
        idle(2, "after_reset");

        // 2. priority and stall counting
        step(0, 1, 0, 0, 6'd0, 32'h0, 32'h0, "id_only");
        step(0, 1, 0, 0, 6'd0, 32'h0, 32'h0, "id_only");
        step(0, 1, 1, 0, 6'd0, 32'h0, 32'h0, "id_and_ex");
        step(0, 1, 1, 0, 6'd0, 32'h0, 32'h0, "id_and_ex");
        idle(1, "idle");

        // 3. multi-cycle op of 5, second start at t+2 ignored
        step(0, 0, 0, 1, 6'd5, 32'h0, 32'h0, "mc5_t");
        step(0, 0, 0, 0, 6'd0, 32'h0, 32'h0, "mc5_t1");
        step(0, 0, 0, 1, 6'd3, 32'h0, 32'h0, "mc5_restart_ignored");
        idle(5, "mc5_tail");
        step(0, 0, 0, 1, 6'd0, 32'h0, 32'h0, "mc0");
        idle(2, "mc0_tail");
        step(0, 0, 0, 1, 6'd1, 32'h0, 32'h0, "mc1");
        idle(2, "mc1_tail");

        // 4. exception vectors
        step(0, 0, 0, 0, 6'd0, 32'h1, 32'h0, "exc_int");
        idle(1, "recover");
        step(0, 0, 0, 0, 6'd0, 32'h8, 32'h0, "exc_syscall");
        idle(1, "recover");
        step(0, 0, 0, 0, 6'd0, 32'he, 32'h0000_1100, "exc_eret");
        idle(1, "recover");
        step(0, 1, 1, 0, 6'd0, 32'ha, 32'h0, "exc_invalid");
        step(0, 0, 0, 0, 6'd0, 32'hd, 32'h0, "exc_trap");
        step(0, 0, 0, 0, 6'd0, 32'h3, 32'h0, "exc_other");
        idle(1, "recover");

        // 5. abort of an 8-cycle op, then RECOVER masking
        step(0, 0, 0, 1, 6'd8, 32'h0, 32'h0, "mc8_t");
        idle(2, "mc8_run");
        step(0, 0, 0, 0, 6'd0, 32'hc, 32'h0, "mc8_abort");
        step(0, 1, 0, 0, 6'd0, 32'h0, 32'h0, "recover_id_masked");
        idle(8, "no_done_after_abort");
        step(0, 0, 0, 0, 6'd0, 32'hc, 32'h0, "exc_ov");
        step(0, 0, 1, 0, 6'd0, 32'h0, 32'h0, "recover_ex_stall");
        idle(1, "idle");

        // 6. reset in the middle of a 6-cycle op
        step(0, 0, 0, 1, 6'd6, 32'h0, 32'h0, "mc6_t");
        step(0, 0, 0, 0, 6'd0, 32'h0, 32'h0, "mc6_t1");
        step(1, 0, 0, 0, 6'd0, 32'h0, 32'h0, "mc6_reset");
        idle(8, "no_done_after_reset");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, id, ex, ms;
            logic [5:0]  n;
            logic [31:0] exc, epc;
            r   = ($urandom_range(0, 79) == 0);
            id  = ($urandom_range(0, 2) == 0);
            ex  = ($urandom_range(0, 5) == 0);
            ms  = ($urandom_range(0, 7) == 0);
            n   = 6'($urandom_range(1, 10));
            exc = ($urandom_range(0, 14) == 0) ? codes[$urandom_range(0, 7)] : 32'h0;
            epc = $urandom;
            step(r, id, ex, ms, n, exc, epc, "random");
        end
        idle(12, "drain");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
